// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one W-bit ALU (IDLE/EXEC/DONE)
// Optional round-robin arbitration when ALU_ARBITER_RR_EN is defined; fixed priority otherwise.
module alu_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [1:0]   op0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [1:0]   op1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt1,
    output logic [W-1:0] res,
    output logic         res_valid,
    output logic         res_id,
    input  logic         res_ready,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         id_q;
    logic         sel;
    logic         xfer;
    logic [W-1:0] alu_out;

`ifdef ALU_ARBITER_RR_EN
    logic last_gnt;

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        sel = 1'b0;
        if (req0 && req1) begin
            sel = ~last_gnt;
        end else begin
            sel = ~req0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (xfer) begin
            last_gnt <= sel;
        end
    end
`else
    always_comb begin
        sel = ~req0;
    end
`endif

    always_comb begin
        case (op_q)
            2'b00:   alu_out = a_q + b_q;
            2'b01:   alu_out = {a_q[W-2:0], 1'b0};
            2'b10:   alu_out = {1'b0, a_q[W-1:1]};
            default: alu_out = ~(a_q & b_q);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                gnt0 = req0 && !sel;
                gnt1 = req1 && sel;
                if (gnt0 || gnt1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = DONE;
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer = gnt0 || gnt1;

    // Operands are latched at the transfer edge so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            res       <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            if (xfer) begin
                op_q <= sel ? op1 : op0;
                a_q  <= sel ? a1 : a0;
                b_q  <= sel ? b1 : b0;
                id_q <= sel;
            end
            if (state == EXEC) begin
                res       <= alu_out;
                res_id    <= id_q;
                res_valid <= 1'b1;
            end else if (state == DONE && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [1:0] op0 = 2'b00;
    logic [1:0] op1 = 2'b00;
    logic [7:0] a0 = 8'h00;
    logic [7:0] b0 = 8'h00;
    logic [7:0] a1 = 8'h00;
    logic [7:0] b1 = 8'h00;
    logic       res_ready = 1'b0;
    logic       gnt0;
    logic       gnt1;
    logic [7:0] res;
    logic       res_valid;
    logic       res_id;
    logic       busy;

    alu_arbiter #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
        .res(res), .res_valid(res_valid), .res_id(res_id),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a * 2) % 256;
            2:       return a / 2;
            default: return 255 - (a & b);
        endcase
    endfunction

    // Transaction-level model: the ALU is either free, computing a job, or holding a result.
    bit m_free = 1, m_comp = 0, m_valid = 0;
    int m_res = 0, m_id = 0, m_last = 1, m_jres = 0, m_jid = 0;
    int eg, cyc = 0;
    bit log_en = 0;
    int g_id[$];
    int g_cyc[$];

    function automatic int winner();
        if (req0 && req1) begin
`ifdef ALU_ARBITER_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_free = 1; m_comp = 0; m_valid = 0; m_res = 0; m_id = 0; m_last = 1;
        end
        eg = m_free ? winner() : -1;
        chk("gnt0", gnt0, eg == 0);
        chk("gnt1", gnt1, eg == 1);
        chk("busy", busy, !m_free);
        chk("res_valid", res_valid, m_valid);
        chk("res", res, m_res);
        chk("res_id", res_id, m_id);
        if (log_en && (gnt0 || gnt1)) begin
            g_id.push_back(gnt1 ? 1 : 0);
            g_cyc.push_back(cyc);
        end
        if (!rst) begin
            if (m_free) begin
                if (eg >= 0) begin
                    m_jres = (eg == 0) ? alu_ref(op0, a0, b0) : alu_ref(op1, a1, b1);
                    m_jid  = eg;
                    m_last = eg;
                    m_free = 0;
                    m_comp = 1;
                end
            end else if (m_comp) begin
                m_comp = 0; m_valid = 1; m_res = m_jres; m_id = m_jid;
            end else if (res_ready) begin
                m_valid = 0; m_free = 1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the ALU idle; ends at the negedge after the result is consumed.
    task automatic do_op(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp);
        res_ready = 1'b1;
        if (id) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
        else    begin req0 = 1; op0 = op; a0 = a; b0 = b; end
        @(negedge clk);
        chk("op_gnt_sel", id ? gnt1 : gnt0, 1);
        chk("op_gnt_oth", id ? gnt0 : gnt1, 0);
        chk("op_busy_pre", busy, 0);
        tick();
        req0 = 0; req1 = 0; a0 = 8'h55; a1 = 8'h55; b0 = 8'hAA; b1 = 8'hAA;
        @(negedge clk);
        chk("op_busy_exec", busy, 1);
        chk("op_valid_exec", res_valid, 0);
        tick();
        @(negedge clk);
        chk("op_valid", res_valid, 1);
        chk("op_res", res, exp);
        chk("op_res_id", res_id, id);
        chk("op_busy_done", busy, 1);
        tick();
        @(negedge clk);
        chk("op_valid_end", res_valid, 0);
        chk("op_busy_end", busy, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_res", res, 8'h00);
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", res_id, 0);

        tick();
        rst = 0;
        do_op(0, 2'b00, 8'hF0, 8'h20, 8'h10);
        tick(); do_op(1, 2'b01, 8'h81, 8'h00, 8'h02);
        tick(); do_op(1, 2'b10, 8'h81, 8'h00, 8'h40);
        tick(); do_op(1, 2'b11, 8'hFF, 8'h0F, 8'hF0);

        tick();
        req0 = 1; op0 = 2'b00; a0 = 8'h03; b0 = 8'h04;
        req1 = 1; op1 = 2'b01; a1 = 8'h40; b1 = 8'h00;
        log_en = 1;
        repeat (12) tick();
        req0 = 0; req1 = 0; log_en = 0;
        chk("cont_count", g_id.size(), 4);
        for (int i = 0; i < 4 && i < g_id.size(); i++) begin
`ifdef ALU_ARBITER_RR_EN
            chk("cont_id", g_id[i], i % 2);
`else
            chk("cont_id", g_id[i], 0);
`endif
            if (i > 0) chk("cont_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end

        tick();
        res_ready = 0;
        req0 = 1; op0 = 2'b10; a0 = 8'h81; b0 = 8'h00;
        @(negedge clk);
        chk("bp_gnt0", gnt0, 1);
        tick();
        req0 = 0; req1 = 1; op1 = 2'b00; a1 = 8'h05; b1 = 8'h06;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_res", res, 8'h40);
            chk("bp_id", res_id, 0);
            chk("bp_gnt", {gnt0, gnt1}, 2'b00);
            chk("bp_busy", busy, 1);
            tick();
        end
        res_ready = 1;
        @(negedge clk);
        chk("bp_valid_last", res_valid, 1);
        tick();
        @(negedge clk);
        chk("bp_valid_drop", res_valid, 0);
        chk("bp_resume_gnt1", gnt1, 1);
        tick();
        req1 = 0;
        repeat (3) tick();

        req1 = 1; op1 = 2'b00; a1 = 8'h01; b1 = 8'h01;
        @(negedge clk);
        chk("mid_gnt1", gnt1, 1);
        tick();
        req1 = 0;
        #1 rst = 1;
        #1;
        chk("mid_valid", res_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_res", res, 8'h00);
        tick();
        rst = 0;
        req0 = 1; op0 = 2'b00; a0 = 8'h07; b0 = 8'h08;
        req1 = 1; op1 = 2'b00; a1 = 8'h01; b1 = 8'h01;
        @(negedge clk);
        chk("post_gnt0", gnt0, 1);
        chk("post_gnt1", gnt1, 0);
        chk("post_res", res, 8'h00);
        tick();
        req0 = 0; req1 = 0;
        tick();
        @(negedge clk);
        chk("post_res_val", res, 8'h0F);
        chk("post_res_id", res_id, 0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
